// File: rtl/display_arb.sv
// Round-robin arbiter granting one of three requesters the hex display, with a
// minimum hold time before preemption. Define BLINK_EN to enable owner-requested blinking.
module display_arb #(
  parameter logic [15:0] HOLD_CYC   = 16'd50000,
  parameter logic [23:0] BLINK_HALF = 24'd12500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] hex0,
  input  logic [15:0] hex1,
  input  logic [15:0] hex2,
  input  logic [3:0]  vld0,
  input  logic [3:0]  vld1,
  input  logic [3:0]  vld2,
  input  logic [2:0]  blink,
  output logic [2:0]  gnt,
  output logic [15:0] four_hex,
  output logic [3:0]  valid,
  output logic        busy
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state, state_d;
  logic [1:0]  ptr, ptr_d, win, cand;
  logic        win_found, new_grant, blank;
  logic [2:0]  own_oh;
  logic [15:0] hold;
  logic [15:0] sel_hex;
  logic [3:0]  sel_vld;

  // ptr always names the current owner while in OWN, so gnt is decoded from it
  assign own_oh = 3'(3'b001 << ptr);
  assign gnt    = (state == OWN) ? own_oh : '0;
  assign busy   = (state == OWN);

  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    cand      = ptr;
    for (int unsigned i = 1; i <= 3; i++) begin
      cand = 2'((32'(ptr) + i) % 3);
      if (!win_found && req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    new_grant = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d   = OWN;
          ptr_d     = win;
          new_grant = 1'b1;
        end
      end
      OWN: begin
        if (!(|(req & own_oh))) begin
          if (|req) begin
            ptr_d     = win;
            new_grant = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (hold == HOLD_CYC && |(req & ~own_oh)) begin
          ptr_d     = win;
          new_grant = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd2;
      hold  <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      if (new_grant || state_d == IDLE)
        hold <= '0;
      else if (hold != HOLD_CYC)
        hold <= hold + 16'd1;
    end
  end

  always_comb begin
    sel_hex = '0;
    sel_vld = '0;
    case (gnt)
      3'b001: begin sel_hex = hex0; sel_vld = vld0; end
      3'b010: begin sel_hex = hex1; sel_vld = vld1; end
      3'b100: begin sel_hex = hex2; sel_vld = vld2; end
      default: ;
    endcase
  end

`ifdef BLINK_EN
  logic [23:0] blink_cnt;
  logic        blink_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_HALF - 24'd1) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  assign blank = !blink_on && |(blink & gnt);
`else
  logic unused_blink;
  assign unused_blink = ^{blink, BLINK_HALF};
  assign blank        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      four_hex <= '0;
      valid    <= '0;
    end else begin
      four_hex <= sel_hex;
      valid    <= blank ? '0 : sel_vld;
    end
  end

endmodule

// File: tb/tb_display_arb.sv
// Directed bench for display_arb (HOLD_CYC=4, BLINK_HALF=8); define BLINK_EN for
// both RTL and bench to exercise the blink path.
module tb_display_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, blink;
  logic [15:0] hexv [3];
  logic [3:0]  vldv [3];
  logic [2:0]  gnt;
  logic [15:0] four_hex;
  logic [3:0]  valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  display_arb #(.HOLD_CYC(16'd4), .BLINK_HALF(24'd8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .hex0(hexv[0]), .hex1(hexv[1]), .hex2(hexv[2]),
    .vld0(vldv[0]), .vld1(vldv[1]), .vld2(vldv[2]),
    .blink(blink), .gnt(gnt), .four_hex(four_hex), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse;
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    int owner;
    int run, trans;
    logic [3:0] prev, v;

    rst_n = 1'b0; req = '0; blink = '0;
    hexv[0] = 16'h1234; hexv[1] = 16'hABCD; hexv[2] = 16'h5678;
    vldv[0] = 4'b1011;  vldv[1] = 4'b0110;  vldv[2] = 4'b1100;

    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_hex", 32'(four_hex), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    #10;
    rst_n = 1'b1;
    req   = 3'b001;

    // single request from reset
    step;
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    check("first_valid_lag", 32'(valid), 32'h0);
    req = 3'b000;
    step;
    check("first_hex", 32'(four_hex), 32'h1234);
    check("first_valid", 32'(valid), 32'hB);
    check("release_gnt", 32'(gnt), 32'h0);
    check("release_busy", 32'(busy), 32'h0);
    step;
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_hex", 32'(four_hex), 32'h0);

    // all requesting: rotate every 5 cycles
    rst_pulse;
    req = 3'b111;
    for (int k = 0; k < 20; k++) begin
      step;
      owner = (k / 5) % 3;
      check("rr_gnt", 32'(gnt), 32'(3'b001 << owner));
      if (k == 0) check("rr_hex0", 32'(four_hex), 32'h0);
      else        check("rr_hex", 32'(four_hex), 32'(hexv[((k - 1) / 5) % 3]));
    end

    // preemption after hold expiry
    rst_pulse;
    req = 3'b001;
    step;
    check("pre_g0", 32'(gnt), 32'h1);
    step;
    check("pre_g1", 32'(gnt), 32'h1);
    req = 3'b011;
    for (int i = 2; i <= 4; i++) begin
      step;
      check("pre_hold", 32'(gnt), 32'h1);
    end
    step;
    check("pre_switch", 32'(gnt), 32'h2);

    // owner drops with another waiting: direct handover, then idle
    req = 3'b100;
    step;
    check("hand_gnt", 32'(gnt), 32'h4);
    check("hand_hex", 32'(four_hex), 32'(hexv[1]));
    req = 3'b000;
    step;
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_valid_lag", 32'(valid), 32'(vldv[2]));
    step;
    check("drop_valid", 32'(valid), 32'h0);

    // asynchronous reset mid-ownership
    req = 3'b100;
    step;
    check("ar_gnt", 32'(gnt), 32'h4);
    step;
    check("ar_valid_pre", 32'(valid), 32'(vldv[2]));
    rst_n = 1'b0;
    #1;
    check("ar_gnt0", 32'(gnt), 32'h0);
    check("ar_hex0", 32'(four_hex), 32'h0);
    check("ar_valid0", 32'(valid), 32'h0);
    check("ar_busy0", 32'(busy), 32'h0);
    #2;
    rst_n = 1'b1;
    req = 3'b011;
    step;
    check("ar_restart", 32'(gnt), 32'h1);

    // blink behaviour
    rst_pulse;
    vldv[0] = 4'b1111;
    blink = 3'b001;
    req = 3'b001;
    step;
    step;
`ifdef BLINK_EN
    prev = valid;
    run = 1;
    trans = 0;
    for (int i = 0; i < 40; i++) begin
      step;
      v = valid;
      check("blink_level", 32'(v == 4'hF || v == 4'h0), 32'h1);
      if (v == prev) begin
        run++;
      end else begin
        if (trans > 0) check("blink_run", 32'(run), 32'd8);
        trans++;
        run = 1;
        prev = v;
      end
    end
    check("blink_toggles", 32'(trans >= 4), 32'h1);
`else
    for (int i = 0; i < 24; i++) begin
      step;
      check("blink_ignored", 32'(valid), 32'hF);
    end
`endif
    blink = 3'b000;
    for (int i = 0; i < 20; i++) begin
      step;
      check("noblink_valid", 32'(valid), 32'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
